// File: rtl/bcd_display_scan.sv
// ---------------------------------------------------------------------------
// bcd_display_scan
//
// Multiplexed driver for a four-digit, common-anode seven-segment display fed
// by a BCD counter chain. A snapshot register captures the counter digits on
// LOAD, and a prescaler/digit-index pair scans the four digits so that each
// one is driven for SCAN_DIV clock cycles. The display shows leading-zero
// blanking (optional) and a sticky overflow indicator on the units decimal
// point.
//
// Parameters
//   SCAN_DIV  clock cycles each digit is driven (>= 1)
//
// Ports
//   CLK       in   clock, all state changes on the rising edge
//   CLR       in   asynchronous active-high reset
//   DIGITS    in   [15:0] BCD digits: [3:0] units .. [15:12] thousands
//   LOAD      in   capture DIGITS into the snapshot register
//   CO_IN     in   carry-out pulse from the top counter digit, sets overflow
//   OVF_ACK   in   clears the overflow flag (CO_IN wins if both are high)
//   BLANK_EN  in   enable leading-zero blanking
//   AN        out  [3:0] digit anodes, active-low, one-hot-low
//   SEG       out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   DP        out  decimal point, active-low
// ---------------------------------------------------------------------------
module bcd_display_scan #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [15:0] DIGITS,
  input  logic        LOAD,
  input  logic        CO_IN,
  input  logic        OVF_ACK,
  input  logic        BLANK_EN,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  // Prescaler width; a divider of 1 still gets a 1-bit counter that simply
  // stays at zero, which makes the index advance on every edge.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  // Segment patterns, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [15:0]   snapshot_reg;
  logic [PW-1:0] presc_reg;
  logic [1:0]    idx_reg;
  logic          ovf_reg;

  logic          presc_wrap;

  assign presc_wrap = (presc_reg == PRESC_LAST);

  // Snapshot of the counter chain. Only this register feeds the display, so
  // the segments never follow DIGITS while the counter is still rippling.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      snapshot_reg <= 16'h0000;
    end else if (LOAD) begin
      snapshot_reg <= DIGITS;
    end
  end

  // Scan timing. Nothing but the clock and reset touches these, so the dwell
  // per digit is exactly SCAN_DIV cycles regardless of LOAD/CO_IN/OVF_ACK.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      presc_reg <= '0;
      idx_reg   <= 2'd0;
    end else if (presc_wrap) begin
      presc_reg <= '0;
      idx_reg   <= idx_reg + 2'd1;  // natural 2-bit wrap 3 -> 0
    end else begin
      presc_reg <= presc_reg + PRESC_ONE;
    end
  end

  // Sticky overflow flag; a carry arriving in the same cycle as the
  // acknowledge must not be lost, so the set term is tested first.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ovf_reg <= 1'b0;
    end else if (CO_IN) begin
      ovf_reg <= 1'b1;
    end else if (OVF_ACK) begin
      ovf_reg <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Leading-zero detection
  // -------------------------------------------------------------------------
  // nib_zero[i]  : snapshot nibble i is zero
  // lead_zero[i] : nibble i and every more significant nibble are zero
  // The units digit is never a leading zero, so a value of 0 shows "0".
  logic [3:0] nib_zero;
  logic [3:0] lead_zero;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib_zero
      assign nib_zero[gi] = (snapshot_reg[gi*4 +: 4] == 4'd0);
    end

    for (gi = 1; gi < 4; gi++) begin : g_lead_zero
      assign lead_zero[gi] = &nib_zero[3:gi];
    end
  endgenerate

  assign lead_zero[0] = 1'b0;

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  logic [3:0] cur_nibble;
  logic       cur_blank;
  logic [6:0] cur_seg;

  assign cur_nibble = snapshot_reg[{idx_reg, 2'b00} +: 4];
  assign cur_blank  = BLANK_EN && lead_zero[idx_reg];

  always_comb begin
    cur_seg = SEG_DASH;
    case (cur_nibble)
      4'd0:    cur_seg = SEG_0;
      4'd1:    cur_seg = SEG_1;
      4'd2:    cur_seg = SEG_2;
      4'd3:    cur_seg = SEG_3;
      4'd4:    cur_seg = SEG_4;
      4'd5:    cur_seg = SEG_5;
      4'd6:    cur_seg = SEG_6;
      4'd7:    cur_seg = SEG_7;
      4'd8:    cur_seg = SEG_8;
      4'd9:    cur_seg = SEG_9;
      default: cur_seg = SEG_DASH;  // 10..15 are not BCD
    endcase
  end

  // A blanked digit keeps its anode asserted so brightness and scan timing
  // are identical whether or not blanking is enabled.
  assign AN  = ~(4'b0001 << idx_reg);
  assign SEG = cur_blank ? SEG_BLANK : cur_seg;
  assign DP  = ~(ovf_reg && (idx_reg == 2'd0));

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 SHALL have parameter: SCAN_DIV, default 1000, number of clock cycles each digit is driven (legal range >= 1).
REQ-002 SHALL have port: CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: CLR  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: DIGITS  input  16  four BCD digits from the counter chain; [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-005 SHALL have port: LOAD  input  1  snapshot strobe; captures DIGITS into the display register.
REQ-006 SHALL have port: CO_IN  input  1  carry-out pulse from the most significant counter digit; sets the overflow flag.
REQ-007 SHALL have port: OVF_ACK  input  1  clears the overflow flag.
REQ-008 SHALL have port: BLANK_EN  input  1  enables leading-zero blanking.
REQ-009 SHALL have port: AN  output  4  digit anode selects, active-low, one-hot-low.
REQ-010 SHALL have port: SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port: DP  output  1  decimal point, active-low.

Function
REQ-012 SHALL hold a 16-bit snapshot register; on a rising edge with LOAD=1, snapshot <= DIGITS, otherwise it holds.
REQ-013 SHALL drive SEG/AN/DP only from registered state (snapshot, digit index, overflow flag, BLANK_EN), never directly from DIGITS.
REQ-014 SHALL keep a prescaler counting 0..SCAN_DIV-1; on the edge where it equals SCAN_DIV-1 it returns to 0 and the digit index advances.
REQ-015 SHALL advance the 2-bit digit index 0->1->2->3->0 (wrap 3->0), so each digit is driven for exactly SCAN_DIV cycles.
REQ-016 SHALL advance the index every cycle when SCAN_DIV=1.
REQ-017 SHALL drive AN low only on bit [index]: idx0=1110, idx1=1101, idx2=1011, idx3=0111.
REQ-018 SHALL decode the selected snapshot nibble to SEG: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 SHALL decode nibble values 10-15 (invalid BCD) to a dash, SEG=0111111.
REQ-020 SHALL blank digit i (SEG=1111111) when BLANK_EN=1, the nibble is 0, and every more-significant nibble is 0.
REQ-021 SHALL never blank the units digit (index 0), so a value of 0000 shows a single "0".
REQ-022 SHALL leave AN asserted for a blanked digit, so scan timing does not change.
REQ-023 SHALL set the overflow flag on a rising edge with CO_IN=1 and clear it on a rising edge with OVF_ACK=1 and CO_IN=0.
REQ-024 SHALL give CO_IN priority over OVF_ACK when both are 1, so the flag is set.
REQ-025 SHALL drive DP=0 only when index=0 and the overflow flag is set; otherwise DP=1.
REQ-026 SHALL show a LOAD captured at edge k in SEG from edge k onward, and a LOAD coincident with an index advance SHALL show the new value on the new digit.
REQ-027 SHALL not let LOAD, CO_IN or OVF_ACK disturb the prescaler or the index.

Reset
REQ-028 SHALL, while CLR=1, force snapshot=0, prescaler=0, index=0 and overflow flag=0, regardless of CLK.
REQ-029 SHALL therefore drive AN=1110, SEG=1000000 and DP=1 during reset and on the first cycle after it.
REQ-030 SHALL, on CLR asserted mid-scan, return to index 0 immediately and restart a full SCAN_DIV dwell on release.

Verification (SCAN_DIV=4)
REQ-031 SHALL verify this scenario: release reset, LOAD with DIGITS=0x1234 -> AN cycles 1110,1101,1011,0111 with 4 cycles each; SEG = 4,3,2,1 patterns in step.
REQ-032 SHALL verify this scenario: LOAD 0x0070, BLANK_EN=1 -> thousands and hundreds SEG=1111111, tens=1111000, units=1000000; with BLANK_EN=0 both leading digits show 1000000.
REQ-033 SHALL verify this scenario: LOAD 0x0000, BLANK_EN=1 -> only units shows "0"; LOAD 0x00A5 -> tens shows 0111111.
REQ-034 SHALL verify this scenario: CO_IN pulse for one cycle -> DP=0 whenever AN=1110, persisting; CO_IN and OVF_ACK together -> flag stays set; OVF_ACK alone -> DP=1.
REQ-035 SHALL verify this scenario: DIGITS changes without LOAD -> SEG unchanged; LOAD on the advance edge -> new digit shows the new value.
REQ-036 SHALL verify this scenario: CLR pulsed asynchronously between clock edges while index=2 -> AN=1110, SEG=1000000, DP=1 immediately; after release, digit 0 is held 4 cycles.
